// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | alu_pkg: ALU operation codes and ALUOp class encodings          |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package alu_pkg;

  localparam int OPCODE_LENGTH = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------+
// | alu_op_decode: combinational ALUOp/funct -> Operation, Illegal  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int OPCODE_LENGTH = alu_pkg::OPCODE_LENGTH
) (
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     Illegal
);

  logic [3:0] w_op;
  logic       w_ill;

  // Unsupported combinations fall back to ADD with Illegal raised
  always_comb begin
    w_op  = OP_ADD;
    w_ill = 1'b0;
    case (ALUOp)
      ALUOP_LDST: w_op = OP_ADD;
      ALUOP_BRANCH: begin
        case (Funct3)
          3'b000, 3'b001: w_op = OP_EQ;
          3'b100, 3'b101: w_op = OP_SLT;
          3'b110, 3'b111: w_op = OP_SUB;
          default:        w_ill = 1'b1;
        endcase
      end
      ALUOP_RTYPE: begin
        if (Funct3 == 3'b000 && Funct7 == F7_ALT) begin
          w_op = OP_SUB;
        end else if (Funct7 != F7_ZERO) begin
          w_ill = 1'b1;
        end else begin
          case (Funct3)
            3'b000:  w_op = OP_ADD;
            3'b111:  w_op = OP_AND;
            3'b110:  w_op = OP_OR;
            3'b100:  w_op = OP_XOR;
            3'b010:  w_op = OP_SLT;
            3'b001:  w_op = OP_SLL;
            3'b101:  w_op = OP_SRL;
            default: w_ill = 1'b1;
          endcase
        end
      end
      default: begin
        case (Funct3)
          3'b000: w_op = OP_ADD;
          3'b111: w_op = OP_AND;
          3'b110: w_op = OP_OR;
          3'b100: w_op = OP_XOR;
          3'b010: w_op = OP_SLT;
          3'b001: if (Funct7 == F7_ZERO) w_op = OP_SLL; else w_ill = 1'b1;
          3'b101: if (Funct7 == F7_ZERO) w_op = OP_SRL; else w_ill = 1'b1;
          default: w_ill = 1'b1;
        endcase
      end
    endcase
  end

  assign Operation = OPCODE_LENGTH'(w_op);
  assign Illegal   = w_ill;

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// +----------------------------------------------------------------+
// | alu_ctrl_stage: ALU control decode behind a 2-entry skid buffer |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int OPCODE_LENGTH = alu_pkg::OPCODE_LENGTH,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     Illegal,
  output logic [CNT_WIDTH-1:0]     illegal_count
);

  logic [OPCODE_LENGTH-1:0] w_dec_op;
  logic                     w_dec_ill;
  logic                     w_accept;
  logic                     w_consume;

  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [OPCODE_LENGTH-1:0] r_out_op;
  logic                     r_out_ill;
  logic                     r_skid_valid;
  logic [OPCODE_LENGTH-1:0] r_skid_op;
  logic                     r_skid_ill;
  logic [CNT_WIDTH-1:0]     r_cnt;

  alu_op_decode #(
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_decode (
    .ALUOp    (ALUOp),
    .Funct3   (Funct3),
    .Funct7   (Funct7),
    .Operation(w_dec_op),
    .Illegal  (w_dec_ill)
  );

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = r_out_valid & out_ready;

  // in_ready is only ever low while the skid holds an entry, so no accept can
  // coincide with a full skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_op     <= '0;
      r_out_ill    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_op    <= '0;
      r_skid_ill   <= 1'b0;
    end else begin
      if (r_skid_valid) begin
        if (w_consume) begin
          r_out_op     <= r_skid_op;
          r_out_ill    <= r_skid_ill;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else begin
          r_in_ready   <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_out_valid || w_consume) begin
          r_out_valid <= 1'b1;
          r_out_op    <= w_dec_op;
          r_out_ill   <= w_dec_ill;
          r_in_ready  <= 1'b1;
        end else begin
          r_skid_valid <= 1'b1;
          r_skid_op    <= w_dec_op;
          r_skid_ill   <= w_dec_ill;
          r_in_ready   <= 1'b0;
        end
      end else begin
        if (w_consume) r_out_valid <= 1'b0;
        r_in_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept && w_dec_ill && (r_cnt != {CNT_WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign Operation     = r_out_op;
  assign Illegal       = r_out_ill;
  assign illegal_count = r_cnt;

endmodule
`default_nettype wire

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 Parameter OPCODE_LENGTH, default 4, width of the ALU Operation code.
REQ-002 Parameter CNT_WIDTH, default 8, width of the illegal-decode counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream decode request present.
REQ-006 in_ready  output  1  stage can accept a request this cycle.
REQ-007 ALUOp  input  2  class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
REQ-008 Funct3  input  3  instruction funct3.
REQ-009 Funct7  input  7  instruction funct7 (I-type: imm[11:5]).
REQ-010 out_valid  output  1  Operation/Illegal valid toward the ALU side.
REQ-011 out_ready  input  1  downstream consumes the output this cycle.
REQ-012 Operation  output  OPCODE_LENGTH  ALU operation code.
REQ-013 Illegal  output  1  decoded combination is unsupported.
REQ-014 illegal_count  output  CNT_WIDTH  saturating count of accepted illegal requests.

Function
REQ-015 Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, EQ 1000.
REQ-016 ALUOp 00 -> ADD, for any Funct3/Funct7.
REQ-017 ALUOp 01: Funct3 000/001 -> EQ; 100/101 -> SLT; 110/111 -> SUB; 010/011 -> ADD with Illegal=1.
REQ-018 ALUOp 10: 000 -> ADD if Funct7=0000000, SUB if 0100000; 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101 SRL.
REQ-019 ALUOp 10: Funct3 011, or any Funct7 other than 0000000 (plus 0100000 only with 000) -> ADD with Illegal=1.
REQ-020 ALUOp 11: 000 ADD; 111 AND; 110 OR; 100 XOR; 010 SLT; Funct7 ignored for these.
REQ-021 ALUOp 11: 001 -> SLL, 101 -> SRL, only when Funct7=0000000; otherwise (incl. SRAI 0100000) ADD with Illegal=1.
REQ-022 ALUOp 11, Funct3 011 -> ADD with Illegal=1.
REQ-023 Transfer in on in_valid & in_ready; out on out_valid & out_ready.
REQ-024 Latency exactly 1 cycle: request accepted at edge N appears on out_valid after edge N if output register empty or draining.
REQ-025 Throughput one request per cycle while out_ready=1.
REQ-026 Storage: output register plus one skid entry (2 entries total); FIFO order preserved.
REQ-027 in_ready is a register output = skid entry empty; no combinational path out_ready -> in_ready.
REQ-028 out_valid=1 while output register holds data; Operation/Illegal stable until consumed.
REQ-029 Output stalled and new request accepted -> request goes to skid; in_ready drops next cycle.
REQ-030 Output consumed while skid full -> skid moves to output; in_ready rises next cycle.
REQ-031 Simultaneous accept and consume with skid empty -> output register reloads directly; out_valid stays 1.
REQ-032 illegal_count increments on each accepted request decoding Illegal=1; saturates at all-ones, never wraps.

Reset
REQ-033 rst_n low asynchronously clears out_valid=0, in_ready=0 during reset, Operation=0000, Illegal=0, illegal_count=0, skid empty.
REQ-034 First rising clk after rst_n deassert: in_ready=1; in-flight requests at reset are discarded, not replayed.

Structure
REQ-035 Shared package alu_pkg holds the Operation code constants, ALUOp class constants and the OPCODE_LENGTH default.
REQ-036 One combinational sub-module alu_op_decode (ALUOp, Funct3, Funct7 -> Operation, Illegal); alu_ctrl_stage wraps it with skid buffer and counter.

Verification
REQ-037 Reset then ALUOp=10, Funct3=000, Funct7=0100000, out_ready=1 -> next cycle out_valid=1, Operation=0110, Illegal=0.
REQ-038 Back-to-back ALUOp=11 {111,110,100,001 f7=0} with out_ready=1 -> Operation 0000,0001,0011,0100 on consecutive cycles, no bubbles.
REQ-039 out_ready=0, send two requests (ADD, XOR) -> in_ready=0 after second; release out_ready -> 0010 then 0011 in order, in_ready=1 one cycle after first drain.
REQ-040 ALUOp=11, Funct3=101, Funct7=0100000 -> Operation=0010, Illegal=1, illegal_count 0 -> 1; 300 such requests -> illegal_count=255.
REQ-041 Assert rst_n=0 mid-stall with both entries full -> outputs cleared immediately without clk edge; after release first new request emerges alone.
REQ-042 Random stimulus against a table reference model: every accepted request emerges exactly once, in order, with matching Operation/Illegal.
